// File: rtl/button_input.sv
// Push-button front end: per-button synchroniser/debouncer lanes feeding a shared press FSM
// that emits registered one-cycle command pulses and the display mode index.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat of value change while TRIP is long-held in menu).

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic nReset,
  input  logic raw_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreeing sample restarts.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync    <= '0;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], ~raw_n};
      if (sync[1] == pressed)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        pressed <= sync[1];
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module button_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 65536,
  parameter int NUM_MODES       = 6,
  parameter int REPEAT_CYCLES   = 8192
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       nMode,
  input  logic       nTrip,
  input  logic [4:0] displayMode,
  output logic [2:0] mode,
  output logic       trip_Reset,
  output logic       wheelsize_menu,
  output logic       wheelsize_digit_change,
  output logic       wheelsize_value_change
);
  localparam int NUM_LANES = 2;  // lane 0 = MODE, lane 1 = TRIP
  localparam int HW        = $clog2(LONG_CYCLES + 1);

  if (NUM_MODES < 1 || NUM_MODES > 8 || REPEAT_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("button_input: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_HELD_M, S_HELD_T, S_BOTH, S_LONG_M, S_LONG_T, S_LOCKOUT
  } state_t;

  logic [NUM_LANES-1:0] raw_n, pressed;
  assign raw_n = {nTrip, nMode};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .Clock  (Clock),
      .nReset (nReset),
      .raw_n  (raw_n[g]),
      .pressed(pressed[g])
    );
  end

  logic pm, pt, menu, hold_full, rpt_fire;
  assign pm        = pressed[0];
  assign pt        = pressed[1];
  assign menu      = displayMode >= 5'(NUM_MODES);

  state_t        state, state_nxt;
  logic [HW-1:0] hold;
  assign hold_full = (hold == HW'(LONG_CYCLES));

  logic [2:0] mode_nxt;
  logic       trip_nxt, menu_nxt, digit_nxt, value_nxt;

  // State register, hold counter and registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state                  <= S_IDLE;
      hold                   <= '0;
      mode                   <= '0;
      trip_Reset             <= 1'b0;
      wheelsize_menu         <= 1'b0;
      wheelsize_digit_change <= 1'b0;
      wheelsize_value_change <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state &&
          (state_nxt == S_HELD_M || state_nxt == S_HELD_T || state_nxt == S_BOTH))
        hold <= '0;
      else if (!hold_full)
        hold <= hold + 1'b1;
      mode                   <= mode_nxt;
      trip_Reset             <= trip_nxt;
      wheelsize_menu         <= menu_nxt;
      wheelsize_digit_change <= digit_nxt;
      wheelsize_value_change <= value_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pm && pt) state_nxt = S_BOTH;
                 else if (pm)  state_nxt = S_HELD_M;
                 else if (pt)  state_nxt = S_HELD_T;
      S_HELD_M:  if (!pm)           state_nxt = S_IDLE;
                 else if (pt)       state_nxt = S_BOTH;
                 else if (hold_full) state_nxt = S_LONG_M;
      S_HELD_T:  if (!pt)           state_nxt = S_IDLE;
                 else if (pm)       state_nxt = S_BOTH;
                 else if (hold_full) state_nxt = S_LONG_T;
      S_BOTH:    if (hold_full || !pm || !pt) state_nxt = S_LOCKOUT;
      S_LONG_M:  if (!pm) state_nxt = S_IDLE;
      S_LONG_T:  if (!pt) state_nxt = S_IDLE;
      S_LOCKOUT: if (!pm && !pt) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rpt;
  logic          rpt_wrap;
  assign rpt_wrap = (rpt == RW'(REPEAT_CYCLES - 1));

  // Phase counter restarts on every entry to LONG_T, so repeats land at LONG_CYCLES + k*REPEAT_CYCLES.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                          rpt <= '0;
    else if (state != S_LONG_T || rpt_wrap) rpt <= '0;
    else                                  rpt <= rpt + 1'b1;
  end

  assign rpt_fire = menu && pt &&
                    ((state == S_HELD_T && state_nxt == S_LONG_T) ||
                     (state == S_LONG_T && rpt_wrap));
`else
  assign rpt_fire = 1'b0;
`endif

  // Output decode: short actions fire on the release cycle; states are disjoint so pulses never overlap.
  always_comb begin
    mode_nxt  = mode;
    trip_nxt  = 1'b0;
    menu_nxt  = 1'b0;
    digit_nxt = 1'b0;
    value_nxt = rpt_fire;
    if (state == S_BOTH && hold_full) begin
      menu_nxt = 1'b1;
      mode_nxt = '0;
    end else if (state == S_HELD_M && !pm) begin
      if (menu) digit_nxt = 1'b1;
      else      mode_nxt  = (mode == 3'(NUM_MODES - 1)) ? 3'd0 : mode + 3'd1;
    end else if (state == S_HELD_T && !pt) begin
      if (menu) value_nxt = 1'b1;
      else      trip_nxt  = 1'b1;
    end
  end
endmodule
